mips_mmio_responder: RTL and testbench

//  Responder end of the processor's data-memory load/store interface, at the MEM stage beside the data RAM.

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_input_sync.sv | 37 +++
 rtl/mips_mmio_responder.sv | 139 +++++++++++++
 tb/tb_mips_mmio_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MIPS MMIO responder: register word offsets,
// TIMER_CTRL bit positions and the address window size.
package mmio_pkg;

  // Size of the decoded window in bytes (Address[7:0] selects within it)
  localparam int WINDOW_BYTES = 256;

  // Register offsets as word indices (Address[7:2]); byte offset = index * 4
  localparam logic [5:0] OFF_PORT_OUT    = 6'h00;  // 0x00
  localparam logic [5:0] OFF_PORT_IN     = 6'h01;  // 0x04
  localparam logic [5:0] OFF_EDGE_STATUS = 6'h02;  // 0x08
  localparam logic [5:0] OFF_EDGE_MASK   = 6'h03;  // 0x0C
  localparam logic [5:0] OFF_TIMER_CNT   = 6'h04;  // 0x10
  localparam logic [5:0] OFF_TIMER_CMP   = 6'h05;  // 0x14
  localparam logic [5:0] OFF_TIMER_CTRL  = 6'h06;  // 0x18

  // TIMER_CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FLAG_BIT = 1;

endpackage

// File: rtl/mmio_input_sync.sv
// N-bit two-flop synchroniser for asynchronous inputs, plus a third flop
// so that a one-cycle rising-edge pulse can be derived per bit.
module mmio_input_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_bits,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;
  logic [WIDTH-1:0] stage3_reg;

  // Synchroniser chain; stage3 holds the previous synchronised sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
      stage3_reg <= '0;
    end else begin
      stage1_reg <= async_bits;
      stage2_reg <= stage1_reg;
      stage3_reg <= stage2_reg;
    end
  end

  assign synced = stage2_reg;

  // Per-bit 0->1 detect on the synchronised value
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
    assign rise[gi] = stage2_reg[gi] & ~stage3_reg[gi];
  end

endmodule

// File: rtl/mips_mmio_responder.sv
// MEM-stage MMIO responder: decodes loads/stores in a 256-byte window and
// serves PORT_OUT, PORT_IN, edge capture/mask and an optional timer.
// Optional timer is built only when MMIO_TIMER_EN is defined; otherwise the
// timer offsets read as 0 and ignore writes.
module mips_mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          IN_WIDTH  = 8,
  parameter int          OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [31:0]          ReadData,
  output logic                 mmio_hit_q,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 irq
);

  logic                hit;
  logic [5:0]          offset;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         rdata_next;
  logic [IN_WIDTH-1:0] port_sync;
  logic [IN_WIDTH-1:0] port_rise;
  logic [IN_WIDTH-1:0] edge_status_reg;
  logic [IN_WIDTH-1:0] edge_status_next;
  logic [IN_WIDTH-1:0] edge_mask_reg;
  logic                timer_irq;
  logic                unused_bits;

  // Byte-lane bits are ignored; upper store bits may be unused for narrow ports
  assign unused_bits = ^{Address[1:0], WriteData};

  assign hit    = (Address[31:8] == BASE_ADDR[31:8]);
  assign offset = Address[7:2];
  assign wr_en  = MemWrite & hit;
  // A simultaneous write wins: the read half of the access is dropped
  assign rd_en  = MemRead & hit & ~MemWrite;

  mmio_input_sync #(.WIDTH(IN_WIDTH)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_bits (PortIn),
    .synced     (port_sync),
    .rise       (port_rise)
  );

  // Edge capture: a new rising edge beats a coincident write-1-to-clear
  for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_edge
    assign edge_status_next[gi] = port_rise[gi] |
        (edge_status_reg[gi] & ~(wr_en && offset == OFF_EDGE_STATUS && WriteData[gi]));
  end

  // Port latch, edge status and mask registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut         <= '0;
      edge_status_reg <= '0;
      edge_mask_reg   <= '0;
    end else begin
      edge_status_reg <= edge_status_next;
      if (wr_en && offset == OFF_PORT_OUT)  PortOut       <= WriteData[OUT_WIDTH-1:0];
      if (wr_en && offset == OFF_EDGE_MASK) edge_mask_reg <= WriteData[IN_WIDTH-1:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_cnt_reg;
  logic [31:0] timer_cmp_reg;
  logic        timer_en_reg;
  logic        timer_flag_reg;
  logic        timer_match;

  assign timer_match = timer_en_reg && (timer_cnt_reg == timer_cmp_reg);

  // Free-running counter with compare-wrap; CPU writes override counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_cnt_reg  <= '0;
      timer_cmp_reg  <= '0;
      timer_en_reg   <= 1'b0;
      timer_flag_reg <= 1'b0;
    end else begin
      if (wr_en && offset == OFF_TIMER_CNT) timer_cnt_reg <= WriteData;
      else if (timer_match)                 timer_cnt_reg <= '0;
      else if (timer_en_reg)                timer_cnt_reg <= timer_cnt_reg + 32'd1;
      if (wr_en && offset == OFF_TIMER_CMP)  timer_cmp_reg <= WriteData;
      if (wr_en && offset == OFF_TIMER_CTRL) timer_en_reg  <= WriteData[CTRL_EN_BIT];
      timer_flag_reg <= timer_match |
          (timer_flag_reg & ~(wr_en && offset == OFF_TIMER_CTRL && WriteData[CTRL_FLAG_BIT]));
    end
  end

  assign timer_irq = timer_flag_reg;
`else
  assign timer_irq = 1'b0;
`endif

  // Read mux over current register contents; unmapped offsets return 0
  always_comb begin
    rdata_next = '0;
    case (offset)
      OFF_PORT_OUT:    rdata_next[OUT_WIDTH-1:0] = PortOut;
      OFF_PORT_IN:     rdata_next[IN_WIDTH-1:0]  = port_sync;
      OFF_EDGE_STATUS: rdata_next[IN_WIDTH-1:0]  = edge_status_reg;
      OFF_EDGE_MASK:   rdata_next[IN_WIDTH-1:0]  = edge_mask_reg;
`ifdef MMIO_TIMER_EN
      OFF_TIMER_CNT:   rdata_next = timer_cnt_reg;
      OFF_TIMER_CMP:   rdata_next = timer_cmp_reg;
      OFF_TIMER_CTRL: begin
        rdata_next[CTRL_EN_BIT]   = timer_en_reg;
        rdata_next[CTRL_FLAG_BIT] = timer_flag_reg;
      end
`endif
      default:         rdata_next = '0;
    endcase
  end

  // Registered load response; ReadData holds when no load hits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData   <= '0;
      mmio_hit_q <= 1'b0;
    end else begin
      mmio_hit_q <= rd_en;
      if (rd_en) ReadData <= rdata_next;
    end
  end

  assign irq = (|(edge_status_reg & edge_mask_reg)) | timer_irq;

endmodule

// File: tb/tb_mips_mmio_responder.sv
// Directed self-checking bench for mips_mmio_responder. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
// Build with +define+MMIO_TIMER_EN to exercise the timer.
module tb_mips_mmio_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        mmio_hit_q;
  logic [31:0] PortOut;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        hq;

  mips_mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .PortIn     (PortIn),
    .ReadData   (ReadData),
    .mmio_hit_q (mmio_hit_q),
    .PortOut    (PortOut),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Called at a falling edge; performs one store at the next rising edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Called at a falling edge; returns the response one cycle after the load
  task automatic load(input logic [31:0] a, output logic [31:0] data, output logic hit);
    Address = a; MemRead = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    MemRead = 1'b0;
    data = ReadData;
    hit  = mmio_hit_q;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = '0;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("reset_portout", PortOut, 32'h0);
    check("reset_hit", {31'b0, mmio_hit_q}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_rdata", ReadData, 32'h0);

    // Put state in place, then abort a store with reset
    store(BASE, 32'h0000_0011);
    check("pre_reset_portout", PortOut, 32'h11);
    load(BASE, rd, hq);
    check("pre_reset_load", rd, 32'h11);
    Address = BASE; WriteData = 32'h1234_5678; MemWrite = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("midstore_reset_portout", PortOut, 32'h0);
    check("midstore_reset_hit", {31'b0, mmio_hit_q}, 32'h0);
    check("midstore_reset_irq", {31'b0, irq}, 32'h0);
    check("midstore_reset_rdata", ReadData, 32'h0);

    // Store / load of PORT_OUT, then back-to-back PORT_IN load
    store(BASE, 32'hDEAD_BEEF);
    check("store_portout", PortOut, 32'hDEAD_BEEF);
    load(BASE, rd, hq);
    check("load_portout_data", rd, 32'hDEAD_BEEF);
    check("load_portout_hit", {31'b0, hq}, 32'h1);
    load(BASE + 32'h4, rd, hq);
    check("b2b_load_portin", rd, 32'h0);
    check("b2b_load_hit", {31'b0, hq}, 32'h1);

    // Read-after-write in consecutive cycles
    store(BASE + 32'hC, 32'h0000_0004);
    load(BASE + 32'hC, rd, hq);
    check("raw_mask", rd, 32'h4);

    // Edge capture: rising on bits 0 and 2
    PortIn = 8'h05;
    idle(2);
    check("irq_after_2_edges", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_after_3_edges", {31'b0, irq}, 32'h1);
    load(BASE + 32'h8, rd, hq);
    check("edge_status", rd, 32'h5);
    load(BASE + 32'h4, rd, hq);
    check("portin_sync", rd, 32'h5);
    store(BASE + 32'h8, 32'h0000_0004);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);
    load(BASE + 32'h8, rd, hq);
    check("edge_status_w1c", rd, 32'h1);

    // Set/clear collision on bit 1: the new edge must win
    PortIn = 8'h07;
    idle(2);
    store(BASE + 32'h8, 32'h0000_0002);
    load(BASE + 32'h8, rd, hq);
    check("edge_set_beats_clear", rd, 32'h3);
    check("irq_masked_off", {31'b0, irq}, 32'h0);

    // Unmapped offset, window miss, ReadData hold
    load(BASE + 32'h40, rd, hq);
    check("unmapped_data", rd, 32'h0);
    check("unmapped_hit", {31'b0, hq}, 32'h1);
    load(BASE, rd, hq);
    check("reload_portout", rd, 32'hDEAD_BEEF);
    load(32'h2000_0000, rd, hq);
    check("miss_hit", {31'b0, hq}, 32'h0);
    check("miss_hold_rdata", rd, 32'hDEAD_BEEF);
    store(32'h2000_0000, 32'h5555_5555);
    check("miss_store_ignored", PortOut, 32'hDEAD_BEEF);

    // Simultaneous read and write: write happens, read dropped
    Address = BASE + 32'hC; WriteData = 32'h0000_00FF; MemWrite = 1'b1; MemRead = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    check("rw_collision_hit", {31'b0, mmio_hit_q}, 32'h0);
    check("rw_collision_rdata_hold", ReadData, 32'hDEAD_BEEF);
    load(BASE + 32'hC, rd, hq);
    check("rw_collision_mask", rd, 32'hFF);
    check("irq_mask_ff", {31'b0, irq}, 32'h1);

`ifdef MMIO_TIMER_EN
    store(BASE + 32'h14, 32'd3);
    store(BASE + 32'h10, 32'd0);
    store(BASE + 32'h18, 32'h1);
    begin
      logic [31:0] seq [5];
      seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
      for (int i = 0; i < 5; i++) begin
        load(BASE + 32'h10, rd, hq);
        check($sformatf("timer_cnt_%0d", i), rd, seq[i]);
      end
    end
    load(BASE + 32'h18, rd, hq);
    check("timer_ctrl_flag", rd, 32'h3);
    store(BASE + 32'h18, 32'h2);
    load(BASE + 32'h18, rd, hq);
    check("timer_flag_cleared", rd, 32'h0);
`else
    store(BASE + 32'h10, 32'h0000_0005);
    load(BASE + 32'h10, rd, hq);
    check("no_timer_cnt_reads_0", rd, 32'h0);
    store(BASE + 32'h18, 32'h0000_0001);
    load(BASE + 32'h18, rd, hq);
    check("no_timer_ctrl_reads_0", rd, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
